// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer: 5 cycles per instruction plus 1 per memory wait cycle.
// Holds IMEM_REQ until IMEM_VALID or until the fetch times out into a sticky TRAP that only RST clears.
module cpu_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_VALID,
  output logic [31:0] IR,
  output logic        DEC_EN,
  output logic        ALU_EN,
  output logic        RF_WE,
  output logic [31:0] PC,
  output logic [31:0] INSTRET,
  output logic        BUSY,
  output logic        TRAP,
  output logic [1:0]  TRAP_CAUSE
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam logic [6:0] OP_ALU      = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM  = 7'b0010011;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        req_q, req_d;
  logic        dec_en_q, dec_en_d;
  logic        alu_en_q, alu_en_d;
  logic        rf_we_q, rf_we_d;
  logic        opcode_legal;

  assign cnt_inc      = cnt_q + 8'd1;
  assign opcode_legal = (ir_q[6:0] == OP_ALU) || (ir_q[6:0] == OP_ALU_IMM);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      dec_en_q  <= 1'b0;
      alu_en_q  <= 1'b0;
      rf_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      dec_en_q  <= dec_en_d;
      alu_en_q  <= alu_en_d;
      rf_we_q   <= rf_we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response on the final allowed cycle still counts as a fetch.
        if (IMEM_VALID) begin
          ir_d    = IMEM_RDATA;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = 2'd2;
          end
        end
      end
      S_DECODE: begin
        if (opcode_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        pc_d      = pc_q + 32'd4;
        instret_d = instret_q + 32'd1;
        state_d   = RUN ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
        cause_d = 2'd0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they leave flops aligned with the state they belong to.
  always_comb begin
    req_d    = (state_d == S_FETCH) || (state_d == S_WAIT);
    dec_en_d = (state_d == S_DECODE);
    alu_en_d = (state_d == S_EXEC);
    rf_we_d  = (state_d == S_WB) && (ir_d[11:7] != 5'd0);
  end

  assign IMEM_REQ   = req_q;
  assign IMEM_ADDR  = pc_q;
  assign IR         = ir_q;
  assign DEC_EN     = dec_en_q;
  assign ALU_EN     = alu_en_q;
  assign RF_WE      = rf_we_q;
  assign PC         = pc_q;
  assign INSTRET    = instret_q;
  assign BUSY       = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign TRAP       = trap_q;
  assign TRAP_CAUSE = cause_q;

endmodule
